yscaler_nn: RTL and testbench
=============================

Name: yscaler_nn

Overview:
- Parametrised nearest-neighbour vertical scaler on an AXI4-Stream video path; successor to the fixed 8-bit upscale-only yscaler.
- Converts an ori_width x ori_height frame into an ori_width x scale_height frame; supports upscale, downscale and 1:1.
- Uses one line buffer: each source line is passed through, repeated, or dropped.
- Sits between the video source (sensor/DMA) and the downstream xscaler/VDMA.

Parameters:
- C_PIXEL_WIDTH, 8, pixel/tdata width in bits.
- C_IMG_WBITS, 12, width of ori_width; line buffer depth is 2**C_IMG_WBITS.
- C_IMG_HBITS, 12, width of ori_height and scale_height.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- ori_width  in  C_IMG_WBITS  pixels per line; sampled at SOF.
- ori_height  in  C_IMG_HBITS  input lines; sampled at SOF.
- scale_height  in  C_IMG_HBITS  output lines; sampled at SOF.
- S_AXIS_tvalid  in  1  input valid.
- S_AXIS_tready  out  1  input ready.
- S_AXIS_tdata  in  C_PIXEL_WIDTH  input pixel.
- S_AXIS_tuser  in  1  start of frame.
- S_AXIS_tlast  in  1  end of line (ignored; line length comes from ori_width).
- M_AXIS_tvalid  out  1  output valid.
- M_AXIS_tready  in  1  output ready.
- M_AXIS_tdata  out  C_PIXEL_WIDTH  output pixel.
- M_AXIS_tuser  out  1  asserted on the first pixel of each output frame.
- M_AXIS_tlast  out  1  asserted on every ori_width-th pixel of a line.

Behaviour:
- Reset (async, resetn=0):
  - M_AXIS_tvalid/tuser/tlast = 0; M_AXIS_tdata = 0; S_AXIS_tready = 0.
  - FSM returns to IDLE; all counters are cleared.
- Line mapping: output line j (0-based) comes from input line floor(j*ori_height/scale_height).
  - n_i = number of output lines mapped to input line i.
  - Computed incrementally: num = j*ori_height (2*C_IMG_HBITS bits, unsigned), bound = (i+1)*scale_height.
  - n_i = count of num values below bound; num += ori_height per emitted line. No multipliers in the datapath.
- FSM states:
  - IDLE:
    - S_AXIS_tready=1; beats without tuser are discarded.
    - A tuser beat latches ori_width, ori_height and scale_height, clears counters, and is treated as pixel 0 of line 0.
    - If any latched dimension is 0, go to DROP for the frame (no output). Otherwise go to PASS or DROP according to n_0.
  - PASS (n_i>=1):
    - Each accepted input pixel is written to linebuf[x] and loaded into the output register.
    - Latency is 1 cycle, accept to M_AXIS_tvalid.
    - S_AXIS_tready = !M_AXIS_tvalid || M_AXIS_tready (registered-output skid rule).
    - After ori_width pixels: go to REPLAY if n_i>1, else advance i.
  - DROP (n_i==0):
    - S_AXIS_tready=1; pixels are written to the buffer but not output.
    - After ori_width pixels, advance i.
  - REPLAY:
    - S_AXIS_tready=0; linebuf is read with 1-cycle read latency into the output register.
    - Same handshake as PASS; no bubbles while M_AXIS_tready=1.
    - Each line is replayed n_i-1 times, then i advances.
  - Advance i: if i==ori_height-1, go to IDLE; else select PASS or DROP from the new n_i.
- Output framing:
  - M_AXIS_tuser=1 only on output pixel (0,0).
  - M_AXIS_tlast when x==ori_width-1.
  - Exactly ori_width*scale_height beats per frame.
- AXI rules: M_AXIS_* hold stable while tvalid && !tready; tvalid never drops without a handshake.
- Mid-frame SOF: an accepted tuser beat outside IDLE aborts the current frame.
  - The partially emitted output frame is truncated; an already-loaded output beat is still delivered.
  - The tuser beat restarts the frame as in IDLE. Downstream resyncs on tuser.
- Boundaries:
  - ori_width=1: every pixel has tlast.
  - ori_height==scale_height: pure pass-through.
  - scale_height<ori_height: some lines are dropped.
  - Input tlast mismatch has no effect on output framing.
- Reset mid-operation: output is cleared immediately; the in-flight frame is lost; a new SOF is awaited.

Decomposition:
- Package yscaler_pkg: FSM state enum (IDLE, PASS, DROP, REPLAY) and function clog2.
- One sub-module: yscaler_linebuf, a simple dual-port RAM (1 write, 1 read, registered read), depth 2**C_IMG_WBITS, width C_PIXEL_WIDTH.

Test Plan:
- W=10, Hin=10, Hout=30, tready=1, pixel=row*10+col -> 30 lines; each input row repeated 3 times consecutively (0..9 x3, 10..19 x3, ...); tuser once; tlast every 10th beat.
- W=10, Hin=10, Hout=4 -> output rows sourced from input rows 0, 2, 5, 7 (first pixels 0, 20, 50, 70); rows 1, 3, 4, 6, 8, 9 dropped.
- W=4, Hin=3, Hout=7 under random 50% tvalid/tready -> row multiplicities 3, 2, 2; 28 beats; AXI stability checker passes; no dropped or duplicated beats.
- W=1, Hin=Hout=5 -> pass-through; 5 beats, each with tlast; tuser on the first; latency exactly 1 cycle with tready=1.
- Second tuser injected at input pixel 23 of a W=10, Hin=10, Hout=30 frame -> frame truncated; new frame starts with M_AXIS_tuser=1 and pixel 0; full 300 beats follow.
- resetn pulsed low mid-REPLAY -> M_AXIS_tvalid=0 asynchronously; after release, beats without tuser are discarded until the next SOF; then a correct frame is produced.

Source files
------------

// File: rtl/yscaler_pkg.sv
// ----------------------------------------------------------------------------
// yscaler_pkg
// Shared definitions for the nearest-neighbour vertical scaler:
//   - yscaler_state_t : control FSM state encoding (also exported for debug)
//   - clog2           : constant-function ceiling log2, used to size RAM ports
// ----------------------------------------------------------------------------
package yscaler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PASS   = 2'd1,
    ST_DROP   = 2'd2,
    ST_REPLAY = 2'd3
  } yscaler_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/yscaler_linebuf.sv
// ----------------------------------------------------------------------------
// yscaler_linebuf
// Simple dual-port line buffer: one write port, one read port with a
// registered read (data appears the cycle after i_re). The read register
// holds its value while i_re is low, so a fetched pixel waits safely until
// the consumer takes it.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address (pixel x)
//   i_wdata  : write data
//   i_re     : read enable
//   i_raddr  : read address
//   o_rdata  : registered read data
// ----------------------------------------------------------------------------
module yscaler_linebuf
  import yscaler_pkg::*;
#(
  parameter int C_DW    = 8,
  parameter int C_DEPTH = 4096,
  localparam int C_AW   = (clog2(C_DEPTH) < 1) ? 1 : clog2(C_DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [C_AW-1:0] i_waddr,
  input  logic [C_DW-1:0] i_wdata,
  input  logic            i_re,
  input  logic [C_AW-1:0] i_raddr,
  output logic [C_DW-1:0] o_rdata
);

  logic [C_DW-1:0] r_mem [C_DEPTH];
  logic [C_DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/yscaler_nn.sv
// ----------------------------------------------------------------------------
// yscaler_nn
// Nearest-neighbour vertical scaler on an AXI4-Stream video path. Output
// line j is taken from input line floor(j*ori_height/scale_height); each
// input line is passed through (and optionally replayed from the line
// buffer) or dropped.
//
// Handshake semantics (both streams): a beat transfers on a rising clk edge
// where tvalid && tready. The output is a single registered stage: while
// M_AXIS_tvalid && !M_AXIS_tready all M_AXIS_* hold, and tvalid only falls
// after a transfer. A new output beat may be loaded when the stage is empty
// or is being emptied in the same cycle (w_free).
//
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   ori_width/ori_height   : input frame size, sampled at start of frame
//   scale_height           : output line count, sampled at start of frame
//   S_AXIS_*               : input video stream (tuser = SOF, tlast ignored)
//   M_AXIS_*               : output video stream (tuser = SOF, tlast = EOL)
//   o_dbg_state            : current control FSM state
// ----------------------------------------------------------------------------
module yscaler_nn
  import yscaler_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS   = 12,
  parameter int C_IMG_HBITS   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [C_IMG_WBITS-1:0]   ori_width,
  input  logic [C_IMG_HBITS-1:0]   ori_height,
  input  logic [C_IMG_HBITS-1:0]   scale_height,
  input  logic                     S_AXIS_tvalid,
  output logic                     S_AXIS_tready,
  input  logic [C_PIXEL_WIDTH-1:0] S_AXIS_tdata,
  input  logic                     S_AXIS_tuser,
  input  logic                     S_AXIS_tlast,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic [C_PIXEL_WIDTH-1:0] M_AXIS_tdata,
  output logic                     M_AXIS_tuser,
  output logic                     M_AXIS_tlast,
  output yscaler_state_t           o_dbg_state
);

  localparam int C_NB = 2 * C_IMG_HBITS;

  // Registers
  yscaler_state_t           r_state;
  logic                     r_alive;   // low during and right after reset
  logic [C_IMG_WBITS-1:0]   r_w;
  logic [C_IMG_HBITS-1:0]   r_h;
  logic [C_IMG_HBITS-1:0]   r_s;
  logic                     r_zero;    // current frame has a zero dimension
  logic [C_IMG_WBITS-1:0]   r_x;       // pixel index within the current line
  logic [C_IMG_HBITS-1:0]   r_i;       // current input line
  logic [C_NB-1:0]          r_num;     // j*ori_height for next output line j
  logic [C_NB-1:0]          r_bound;   // (i+1)*scale_height
  logic [C_IMG_WBITS-1:0]   r_rx;      // replay read address
  logic                     r_rd_pend; // linebuf read data valid, not yet used
  logic                     r_m_valid;
  logic [C_PIXEL_WIDTH-1:0] r_m_data;
  logic                     r_m_user;
  logic                     r_m_last;

  // Wires
  logic                     w_free;
  logic                     w_ready;
  logic                     w_s_ready;
  logic                     w_s_acc;
  logic                     w_sof;
  logic                     w_pix;
  logic                     w_dims_zero;
  yscaler_state_t           w_ctx_state;
  logic                     w_ctx_zero;
  logic [C_IMG_WBITS-1:0]   w_ctx_w;
  logic [C_IMG_HBITS-1:0]   w_ctx_h;
  logic [C_IMG_HBITS-1:0]   w_ctx_s;
  logic [C_IMG_WBITS-1:0]   w_ctx_x;
  logic [C_IMG_HBITS-1:0]   w_ctx_i;
  logic [C_NB-1:0]          w_ctx_num;
  logic [C_NB-1:0]          w_ctx_bound;
  logic                     w_x_last;
  logic                     w_replay;
  logic                     w_rd_consume;
  logic                     w_rd_issue;
  logic                     w_step;
  logic                     w_line_end;
  logic                     w_load;
  logic [C_NB-1:0]          w_num_a;
  logic                     w_more;
  logic                     w_last_line;
  logic [C_NB-1:0]          w_bound_n;
  logic                     w_next_emit;
  logic [C_IMG_WBITS-1:0]   w_rx_next;
  logic [C_PIXEL_WIDTH-1:0] w_rd_data;
  logic                     w_unused_tlast;

  // Line length comes from ori_width, so input tlast carries no information.
  assign w_unused_tlast = S_AXIS_tlast;

  assign w_free = !r_m_valid || M_AXIS_tready;

  // A tuser beat would load the output register, so in IDLE/DROP it is held
  // off until the output stage can take it; other beats pass freely there.
  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      ST_PASS:   w_ready = w_free;
      ST_REPLAY: w_ready = 1'b0;
      default:   w_ready = !S_AXIS_tuser || w_free;
    endcase
  end

  assign w_s_ready = r_alive && w_ready;
  assign w_s_acc   = S_AXIS_tvalid && w_s_ready;
  assign w_sof     = w_s_acc && S_AXIS_tuser;
  assign w_pix     = w_s_acc && (w_sof || (r_state == ST_PASS) || (r_state == ST_DROP));

  assign w_dims_zero = (ori_width == '0) || (ori_height == '0) || (scale_height == '0);

  // Effective frame/line context for this cycle. An SOF beat is pixel 0 of
  // line 0 of a fresh frame, so it is processed against freshly latched
  // values instead of the registered ones. Line 0 always has n_0 >= 1.
  assign w_ctx_state = w_sof ? (w_dims_zero ? ST_DROP : ST_PASS) : r_state;
  assign w_ctx_zero  = w_sof ? w_dims_zero  : r_zero;
  assign w_ctx_w     = w_sof ? ori_width    : r_w;
  assign w_ctx_h     = w_sof ? ori_height   : r_h;
  assign w_ctx_s     = w_sof ? scale_height : r_s;
  assign w_ctx_x     = w_sof ? '0 : r_x;
  assign w_ctx_i     = w_sof ? '0 : r_i;
  assign w_ctx_num   = w_sof ? '0 : r_num;
  assign w_ctx_bound = w_sof ? C_NB'(scale_height) : r_bound;

  assign w_x_last = (w_ctx_x == w_ctx_w - C_IMG_WBITS'(1));

  // Replay read pipeline: fetch when nothing is pending or the pending pixel
  // is moved to the output this cycle. The address wraps so the next replay
  // of the same line is prefetched without a bubble.
  assign w_replay     = (r_state == ST_REPLAY);
  assign w_rd_consume = w_replay && r_rd_pend && w_free;
  assign w_rd_issue   = w_replay && (!r_rd_pend || w_rd_consume);
  assign w_rx_next    = (r_rx == r_w - C_IMG_WBITS'(1)) ? '0 : r_rx + C_IMG_WBITS'(1);

  assign w_step     = w_pix || w_rd_consume;
  assign w_line_end = w_step && !w_ctx_zero && w_x_last;
  assign w_load     = (w_pix && (w_ctx_state == ST_PASS)) || w_rd_consume;

  // Emitting a line advances j; the same input line is emitted again while
  // j*ori_height is still below (i+1)*scale_height.
  assign w_num_a     = (w_ctx_state == ST_DROP) ? w_ctx_num : w_ctx_num + C_NB'(w_ctx_h);
  assign w_more      = (w_ctx_state != ST_DROP) && (w_num_a < w_ctx_bound);
  assign w_last_line = (w_ctx_i == w_ctx_h - C_IMG_HBITS'(1));
  assign w_bound_n   = w_ctx_bound + C_NB'(w_ctx_s);
  assign w_next_emit = (w_num_a < w_bound_n);

  yscaler_linebuf #(
    .C_DW    (C_PIXEL_WIDTH),
    .C_DEPTH (2 ** C_IMG_WBITS)
  ) u_linebuf (
    .clk     (clk),
    .i_we    (w_pix),
    .i_waddr (w_ctx_x),
    .i_wdata (S_AXIS_tdata),
    .i_re    (w_rd_issue),
    .i_raddr (r_rx),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_alive   <= 1'b0;
      r_w       <= '0;
      r_h       <= '0;
      r_s       <= '0;
      r_zero    <= 1'b0;
      r_x       <= '0;
      r_i       <= '0;
      r_num     <= '0;
      r_bound   <= '0;
      r_rx      <= '0;
      r_rd_pend <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_user  <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_alive <= 1'b1;

      if (w_sof) begin
        r_w    <= ori_width;
        r_h    <= ori_height;
        r_s    <= scale_height;
        r_zero <= w_dims_zero;
      end

      // Line/frame sequencing
      if (w_step) begin
        r_i     <= w_ctx_i;
        r_num   <= w_ctx_num;
        r_bound <= w_ctx_bound;
        if (w_line_end) begin
          r_x <= '0;
          if (w_more) begin
            r_state <= ST_REPLAY;
            r_num   <= w_num_a;
          end else if (w_last_line) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= w_next_emit ? ST_PASS : ST_DROP;
            r_i     <= w_ctx_i + C_IMG_HBITS'(1);
            r_num   <= w_num_a;
            r_bound <= w_bound_n;
          end
        end else begin
          r_x     <= w_ctx_x + C_IMG_WBITS'(1);
          r_state <= w_ctx_state;
        end
      end

      // Replay read pipeline; a prefetch beyond the final replay is discarded
      if (w_rd_issue) begin
        r_rx <= w_rx_next;
      end
      r_rd_pend <= w_rd_issue || (r_rd_pend && !w_rd_consume);
      if (w_rd_consume && w_line_end && !w_more) begin
        r_rx      <= '0;
        r_rd_pend <= 1'b0;
      end

      // Registered output stage
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_replay ? w_rd_data : S_AXIS_tdata;
        r_m_user  <= w_sof;
        r_m_last  <= w_x_last;
      end else if (M_AXIS_tready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign S_AXIS_tready = w_s_ready;
  assign M_AXIS_tvalid = r_m_valid;
  assign M_AXIS_tdata  = r_m_data;
  assign M_AXIS_tuser  = r_m_user;
  assign M_AXIS_tlast  = r_m_last;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_yscaler_nn.sv
// ----------------------------------------------------------------------------
// tb_yscaler_nn
// Self-checking bench for yscaler_nn. Expected output frames come from a
// reference model that maps output line j to input line j*Hin/Hout and
// lists the resulting beats; a monitor captures output transfers and checks
// that held beats stay stable.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_yscaler_nn;
  import yscaler_pkg::*;

  localparam int PW = 8;
  localparam int WB = 12;
  localparam int HB = 12;
  localparam int BW = PW + 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic [WB-1:0]  ori_width;
  logic [HB-1:0]  ori_height;
  logic [HB-1:0]  scale_height;
  logic           s_valid, s_ready, s_user, s_last;
  logic [PW-1:0]  s_data;
  logic           m_valid, m_ready, m_user, m_last;
  logic [PW-1:0]  m_data;
  yscaler_state_t dbg_state;

  yscaler_nn #(
    .C_PIXEL_WIDTH (PW),
    .C_IMG_WBITS   (WB),
    .C_IMG_HBITS   (HB)
  ) dut (
    .clk           (clk),
    .resetn        (rst_n),
    .ori_width     (ori_width),
    .ori_height    (ori_height),
    .scale_height  (scale_height),
    .S_AXIS_tvalid (s_valid),
    .S_AXIS_tready (s_ready),
    .S_AXIS_tdata  (s_data),
    .S_AXIS_tuser  (s_user),
    .S_AXIS_tlast  (s_last),
    .M_AXIS_tvalid (m_valid),
    .M_AXIS_tready (m_ready),
    .M_AXIS_tdata  (m_data),
    .M_AXIS_tuser  (m_user),
    .M_AXIS_tlast  (m_last),
    .o_dbg_state   (dbg_state)
  );

  // Scoreboard state
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int            acc_cyc[$];
  int            got_cyc[$];
  logic [PW-1:0] img[$];
  int            n_vec = 0;
  int            n_err = 0;
  bit            rdy_rand = 1'b0;
  bit            vld_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: capture transfers, check stability of stalled beats
  logic          prev_hold = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold)
        chk("axi_hold", {22'd0, m_valid, m_user, m_last, m_data}, {22'd0, 1'b1, prev_beat});
      prev_hold = m_valid && !m_ready;
      prev_beat = {m_user, m_last, m_data};
      if (m_valid && m_ready) begin
        got_q.push_back({m_user, m_last, m_data});
        got_cyc.push_back(cyc);
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Reference model: list the beats of an output frame. With cut >= 0 the
  // input frame was aborted after 'cut' pixels, so only beats whose source
  // pixels had arrived (a replay needs the whole source line) come out.
  task automatic model_frame(input int w, input int h, input int s, input int cut);
    int src, need, prev_src;
    bit stop;
    logic [BW-1:0] b;
    prev_src = -1;
    stop = 1'b0;
    if (w == 0 || h == 0 || s == 0) return;
    for (int j = 0; j < s && !stop; j++) begin
      src = (j * h) / s;
      for (int x = 0; x < w && !stop; x++) begin
        need = (src == prev_src) ? src * w + w - 1 : src * w + x;
        if (cut >= 0 && need >= cut) stop = 1'b1;
        else begin
          b = {(j == 0 && x == 0), (x == w - 1), img[src * w + x]};
          exp_q.push_back(b);
        end
      end
      prev_src = src;
    end
  endtask

  task automatic fill_img(input int w, input int h, input bit rnd);
    img.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        img.push_back(rnd ? PW'($urandom) : PW'(r * w + c));
  endtask

  // Driver
  task automatic send_beat(input logic [PW-1:0] d, input logic u);
    int t;
    logic acc;
    if (vld_rand)
      while ($urandom_range(0, 1) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    s_valid = 1'b1;
    s_data  = d;
    s_user  = u;
    s_last  = 1'($urandom_range(0, 1));
    t = 0;
    acc = 1'b0;
    while (!acc && t < 2000) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      t++;
    end
    chk("s_accept", {31'd0, acc}, 32'd1);
    if (acc) acc_cyc.push_back(cyc);
    s_valid = 1'b0;
    s_user  = 1'b0;
  endtask

  task automatic send_frame(input int n);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) send_beat(img[k], k == 0);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_beat"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic set_dims(input int w, input int h, input int s);
    ori_width    = WB'(w);
    ori_height   = HB'(h);
    scale_height = HB'(s);
  endtask

  task automatic run_frame(input int w, input int h, input int s, input bit rnd, input string tag);
    set_dims(w, h, s);
    fill_img(w, h, rnd);
    model_frame(w, h, s, -1);
    send_frame(w * h);
    drain(tag);
  endtask

  // Directed sequence
  initial begin
    int t;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_user  = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    set_dims(0, 0, 0);
    repeat (3) @(posedge clk); #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_user",  {31'd0, m_user},  32'd0);
    chk("rst_m_last",  {31'd0, m_last},  32'd0);
    chk("rst_m_data",  {24'd0, m_data},  32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_s_ready", {31'd0, s_ready}, 32'd1);

    // Upscale x3, then decimation
    run_frame(10, 10, 30, 1'b0, "up3");
    run_frame(10, 10, 4, 1'b0, "down");

    // Random handshakes on both sides
    vld_rand = 1'b1;
    rdy_rand = 1'b1;
    run_frame(4, 3, 7, 1'b1, "rand437");
    for (int k = 0; k < 4; k++)
      run_frame($urandom_range(1, 12), $urandom_range(1, 6), $urandom_range(1, 14), 1'b1, "rand_dims");
    run_frame(3, 2, 0, 1'b1, "zero_dim");
    run_frame(6, 4, 4, 1'b1, "one2one");
    vld_rand = 1'b0;
    rdy_rand = 1'b0;

    // Width 1 pass-through with latency check
    acc_cyc.delete();
    got_cyc.delete();
    run_frame(1, 5, 5, 1'b1, "w1");
    chk("w1_lat_count", 32'(got_cyc.size()), 32'(acc_cyc.size()));
    for (int k = 0; k < 5 && k < got_cyc.size() && k < acc_cyc.size(); k++)
      chk("w1_latency", 32'(got_cyc[k]), 32'(acc_cyc[k]));

    // Mid-frame SOF at input pixel 23
    set_dims(10, 10, 30);
    fill_img(10, 10, 1'b0);
    model_frame(10, 10, 30, 23);
    send_frame(23);
    fill_img(10, 10, 1'b1);
    model_frame(10, 10, 30, -1);
    send_frame(100);
    drain("midsof");

    // Reset during replay
    set_dims(8, 2, 6);
    fill_img(8, 2, 1'b1);
    send_frame(8);
    t = 0;
    while (dbg_state != ST_REPLAY && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("reach_replay", {30'd0, dbg_state}, {30'd0, ST_REPLAY});
    repeat (2) @(posedge clk);
    #2;
    chk("replay_valid", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("arst_m_data",  {24'd0, m_data},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) send_beat(PW'($urandom), 1'b0);
    repeat (5) @(negedge clk);
    chk("no_sof_discard", 32'(got_q.size()), 32'd0);
    run_frame(8, 2, 6, 1'b1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
